// File: rtl/exec_pkg.sv
// Shared op-code, functional-unit and state definitions for the execute stage.
package exec_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SGEZ = 4'b1000;

  localparam logic [1:0] FU_ALU   = 2'b00;
  localparam logic [1:0] FU_SHIFT = 2'b01;
  localparam logic [1:0] FU_MUL   = 2'b10;
  localparam logic [1:0] FU_RSVD  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, fixed WIDTH-cycle latency.
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             last;

  assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign last  = busy_q && (cnt_q == CW'(WIDTH - 1));

  // The product is taken from acc_d so it is ready in the same cycle as the final add.
  assign done_o    = last;
  assign product_o = acc_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (last) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute unit: single-cycle ALU/shifter, multi-cycle iterative multiplier behind a two-state FSM.
module alu_exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ALU_operation_i,
  input  logic [1:0]       FURslt_i,
  input  logic             leftRight_i,
  input  logic [4:0]       shamt_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             valid_o
);

  state_e           state_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             valid_q;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] shift_res;
  logic [WIDTH-1:0] exec_res;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  // Handshake: an op transfers on a rising edge with valid_i && ready_o; upstream holds
  // its inputs stable until then. valid_o is a one-cycle pulse, result_o/zero_o hold otherwise.
  assign ready_o   = (state_q == IDLE) && !rst_i;
  assign accept    = valid_i && ready_o;
  assign mul_start = accept && (FURslt_i == FU_MUL);

  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign valid_o  = valid_q;

  always_comb begin
    alu_res = '0;
    case (ALU_operation_i)
      OP_AND:  alu_res = src1_i & src2_i;
      OP_OR:   alu_res = src1_i | src2_i;
      OP_ADD:  alu_res = src1_i + src2_i;
      OP_SUB:  alu_res = src1_i - src2_i;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      OP_NOR:  alu_res = ~(src1_i | src2_i);
      OP_SGEZ: alu_res = {{(WIDTH-1){1'b0}}, ~src1_i[WIDTH-1]};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    shift_res = leftRight_i ? (src2_i >> shamt_i) : (src2_i << shamt_i);
    exec_res  = '0;
    case (FURslt_i)
      FU_ALU:   exec_res = alu_res;
      FU_SHIFT: exec_res = shift_res;
      default:  exec_res = '0;
    endcase
  end

  mul_iter #(.WIDTH(WIDTH)) u_mul_iter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start),
    .mcand_i   (src1_i),
    .mplier_i  (src2_i),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (FURslt_i == FU_MUL) begin
              state_q <= MUL;
            end else begin
              result_q <= exec_res;
              zero_q   <= (exec_res == '0);
              valid_q  <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            result_q <= mul_product;
            zero_q   <= (mul_product == '0);
            valid_q  <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed corner cases, then random ops against an arithmetic reference model.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic [3:0]   ALU_operation_i;
  logic [1:0]   FURslt_i;
  logic         leftRight_i;
  logic [4:0]   shamt_i;
  logic [W-1:0] src1_i;
  logic [W-1:0] src2_i;
  logic [W-1:0] result_o;
  logic         zero_o;
  logic         valid_o;

  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .ALU_operation_i (ALU_operation_i),
    .FURslt_i        (FURslt_i),
    .leftRight_i     (leftRight_i),
    .shamt_i         (shamt_i),
    .src1_i          (src1_i),
    .src2_i          (src2_i),
    .result_o        (result_o),
    .zero_o          (zero_o),
    .valid_o         (valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model straight from the op definitions; multiply uses native arithmetic.
  function automatic logic [W-1:0] model(input logic [1:0] fu, input logic [3:0] op,
                                         input logic lr, input logic [4:0] sh,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (fu)
      2'd0: begin
        case (op)
          4'd0:    return a & b;
          4'd1:    return a | b;
          4'd2:    return a + b;
          4'd6:    return a - b;
          4'd7:    return (sa < sb) ? 1 : 0;
          4'd12:   return ~(a | b);
          4'd8:    return (sa >= 0) ? 1 : 0;
          default: return 0;
        endcase
      end
      2'd1:    return lr ? (b >> sh) : (b << sh);
      2'd2: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return p[W-1:0];
      end
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [1:0] fu, input logic [3:0] op,
                        input logic lr, input logic [4:0] sh,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    valid_i         = v;
    FURslt_i        = fu;
    ALU_operation_i = op;
    leftRight_i     = lr;
    shamt_i         = sh;
    src1_i          = a;
    src2_i          = b;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issues one op from IDLE and checks its result pulse; for multiplies, valid_i is held
  // high with a decoy ADD while the unit is busy, which must not be captured.
  task automatic run_op(input string tag, input logic [1:0] fu, input logic [3:0] op,
                        input logic lr, input logic [4:0] sh,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] exp;
    int waited;
    exp_q.push_back(model(fu, op, lr, sh, a, b));
    set_in(1'b1, fu, op, lr, sh, a, b);
    chk({tag, "_ready"}, W'(ready_o), W'(1));
    tick();
    if (fu == 2'd2) begin
      set_in(1'b1, 2'd0, 4'd2, 1'b0, 5'd0, $urandom, $urandom);
      waited = 0;
      while (valid_o !== 1'b1 && waited < W + 5) begin
        chk({tag, "_busy_ready"}, W'(ready_o), W'(0));
        tick();
        waited++;
      end
      valid_i = 1'b0;
      chk({tag, "_latency"}, W'(waited), W'(W));
    end else begin
      valid_i = 1'b0;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk({tag, "_valid"}, W'(valid_o), W'(1));
    chk({tag, "_result"}, result_o, exp);
    chk({tag, "_zero"}, W'(zero_o), W'(exp == '0));
    last_res = exp;
  endtask

  initial begin
    int n_mul;
    logic [1:0] fu;

    rst_i = 1'b1;
    set_in(1'b0, 2'd0, 4'd0, 1'b0, 5'd0, '0, '0);
    repeat (2) tick();
    chk("rst_ready", W'(ready_o), W'(0));
    chk("rst_valid", W'(valid_o), W'(0));
    chk("rst_result", result_o, '0);
    chk("rst_zero", W'(zero_o), W'(1));
    rst_i = 1'b0;
    tick();

    run_op("add_wrap", 2'd0, 4'b0010, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h1);
    chk("add_wrap_const", result_o, 32'h0);
    run_op("slt_neg", 2'd0, 4'b0111, 1'b0, 5'd0, 32'hFFFF_FFFE, 32'h1);
    chk("slt_neg_const", result_o, 32'h1);
    run_op("sgez_neg", 2'd0, 4'b1000, 1'b0, 5'd0, 32'h8000_0000, 32'h0);
    chk("sgez_neg_const", result_o, 32'h0);
    run_op("shr4", 2'd1, 4'd0, 1'b1, 5'd4, 32'h0, 32'h8000_0001);
    chk("shr4_const", result_o, 32'h0800_0000);
    run_op("shl4", 2'd1, 4'd0, 1'b0, 5'd4, 32'h0, 32'h8000_0001);
    chk("shl4_const", result_o, 32'h0000_0010);
    run_op("rsvd", 2'd3, 4'd2, 1'b0, 5'd0, 32'h1234, 32'h5678);

    // Idle cycle: no pulse, result holds.
    tick();
    chk("idle_valid", W'(valid_o), W'(0));
    chk("idle_hold", result_o, last_res);

    set_in(1'b1, 2'd0, 4'b0000, 1'b0, 5'd0, 32'hF0F0, 32'hFF00);
    tick();
    chk("b2b_and_valid", W'(valid_o), W'(1));
    chk("b2b_and", result_o, 32'h0000_F000);
    chk("b2b_ready", W'(ready_o), W'(1));
    set_in(1'b1, 2'd0, 4'b0001, 1'b0, 5'd0, 32'hF0F0, 32'hFF00);
    tick();
    chk("b2b_or_valid", W'(valid_o), W'(1));
    chk("b2b_or", result_o, 32'h0000_FFF0);
    set_in(1'b1, 2'd0, 4'b1100, 1'b0, 5'd0, 32'hF0F0, 32'hFF00);
    tick();
    valid_i = 1'b0;
    chk("b2b_nor_valid", W'(valid_o), W'(1));
    chk("b2b_nor", result_o, 32'hFFFF_000F);
    chk("b2b_nor_zero", W'(zero_o), W'(0));
    tick();
    chk("b2b_end_valid", W'(valid_o), W'(0));

    run_op("mul_dir", 2'd2, 4'd0, 1'b0, 5'd0, 32'h0001_0003, 32'h0002_0005);
    chk("mul_dir_const", result_o, 32'h000B_000F);
    tick();
    chk("mul_after_valid", W'(valid_o), W'(0));
    chk("mul_after_hold", result_o, 32'h000B_000F);

    // Abort a multiply with reset at MUL cycle 10, then issue ADD as reset falls.
    set_in(1'b1, 2'd2, 4'd0, 1'b0, 5'd0, 32'h0001_0003, 32'h0002_0005);
    tick();
    valid_i = 1'b0;
    repeat (9) tick();
    chk("abort_busy", W'(ready_o), W'(0));
    rst_i = 1'b1;
    #1;
    chk("abort_rst_ready", W'(ready_o), W'(0));
    tick();
    chk("abort_valid", W'(valid_o), W'(0));
    chk("abort_result", result_o, '0);
    chk("abort_zero", W'(zero_o), W'(1));
    rst_i = 1'b0;
    set_in(1'b1, 2'd0, 4'b0010, 1'b0, 5'd0, 32'd2, 32'd3);
    #1;
    chk("post_rst_ready", W'(ready_o), W'(1));
    tick();
    valid_i = 1'b0;
    chk("post_rst_add_valid", W'(valid_o), W'(1));
    chk("post_rst_add", result_o, 32'd5);
    for (int i = 0; i < W + 4; i++) begin
      tick();
      chk("abort_no_pulse", W'(valid_o), W'(0));
    end

    n_mul = 0;
    for (int i = 0; i < 150; i++) begin
      fu = 2'($urandom_range(0, 3));
      if (fu == 2'd2) begin
        if (n_mul >= 10) fu = 2'd0;
        else n_mul++;
      end
      run_op("rand", fu, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)),
             ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
             ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom);
      if ($urandom_range(0, 3) == 0) begin
        tick();
        chk("rand_idle_valid", W'(valid_o), W'(0));
        chk("rand_idle_hold", result_o, last_res);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
